pe_datapath_os_fi: RTL and testbench

Parametrised next-generation output-stationary PE datapath with run-time programmable fault injection.
- Computes an unsigned multiply-accumulate of the west operand in_a and the north operand in_b, forwards both operands systolically, and drains partial sums down the column chain.
- Generalises the fixed-target, bit-flip-only PE:
  - accumulator width is a parameter, with optional saturation;
  - fault target and fault model (bit-flip, stuck-at-0, stuck-at-1) are selected at run time;
  - a cycle-timed fault window is driven by an arm/active/done FSM;
  - a fault-hit counter is provided for campaign bookkeeping.

---
 rtl/pe_fi_pkg.sv | 41 ++++
 rtl/pe_fault_ctrl.sv | 126 ++++++++++++
 rtl/pe_datapath_os_fi.sv | 195 +++++++++++++++++++
 tb/tb_pe_datapath_os_fi.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_fi_pkg.sv
// pe_fi_pkg
// Shared definitions for the fault-injecting output-stationary PE:
//   - fault target codes (which datapath value gets corrupted)
//   - fault model codes (how the masked bits are corrupted)
//   - fault window FSM state encoding
//   - fault_bit(): single-bit fault function, used bit-by-bit in generate loops
package pe_fi_pkg;

    typedef enum logic [1:0] {
        TGT_W    = 2'd0,   // north operand (weight, b)
        TGT_A    = 2'd1,   // west operand (input, a)
        TGT_P    = 2'd2,   // accumulator / psum
        TGT_NONE = 2'd3    // no fault
    } fi_target_e;

    typedef enum logic [1:0] {
        FM_FLIP = 2'd0,
        FM_SA0  = 2'd1,
        FM_SA1  = 2'd2,
        FM_RSVD = 2'd3     // behaves as a flip
    } fi_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } fi_state_e;

    // Fault function for one bit: x is the raw bit, m its mask bit.
    function automatic logic fault_bit(input logic x, input logic m, input fi_mode_e mode);
        logic r;
        case (mode)
            FM_SA0:  r = x & ~m;
            FM_SA1:  r = x | m;
            default: r = x ^ m;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pe_fault_ctrl.sv
// pe_fault_ctrl
// Holds the latched fault configuration and the cycle-timed fault window FSM
// (IDLE -> ARMED -> ACTIVE -> DONE) plus the arm delay, remaining-length and
// hit counters.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_we_i          load configuration, clear counters and (re)arm
//   cfg_target_i      fault target code
//   cfg_mode_i        fault model code
//   cfg_mask_i        fault bit mask
//   cfg_start_i       cycles from arm to fault onset
//   cfg_len_i         fault duration in cycles, 0 = permanent
//   active_o          FSM is in ACTIVE (fault is being applied this cycle)
//   target_o, mode_o, mask_o  latched configuration
//   hits_o            ACTIVE cycles since last arm, saturating
module pe_fault_ctrl
    import pe_fi_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we_i,
    input  logic [1:0]       cfg_target_i,
    input  logic [1:0]       cfg_mode_i,
    input  logic [ACC_W-1:0] cfg_mask_i,
    input  logic [CNT_W-1:0] cfg_start_i,
    input  logic [CNT_W-1:0] cfg_len_i,
    output logic             active_o,
    output fi_target_e       target_o,
    output fi_mode_e         mode_o,
    output logic [ACC_W-1:0] mask_o,
    output logic [CNT_W-1:0] hits_o
);

    fi_state_e        state_q, state_d;
    fi_target_e       tgt_q, tgt_d;
    fi_mode_e         mode_q, mode_d;
    logic [ACC_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] start_q, start_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] hits_q, hits_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tgt_q   <= TGT_W;
            mode_q  <= FM_FLIP;
            mask_q  <= '0;
            start_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            hits_q  <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            start_q <= start_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            hits_q  <= hits_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        start_d = start_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        hits_d  = hits_q;
        if (cfg_we_i) begin
            // A new configuration always wins, even mid-window: the running
            // fault ends at this edge.
            tgt_d   = fi_target_e'(cfg_target_i);
            mode_d  = fi_mode_e'(cfg_mode_i);
            mask_d  = cfg_mask_i;
            start_d = cfg_start_i;
            len_d   = cfg_len_i;
            cnt_d   = '0;
            rem_d   = '0;
            hits_d  = '0;
            state_d = (fi_target_e'(cfg_target_i) == TGT_NONE) ? ST_IDLE : ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (cnt_q == start_q) begin
                        state_d = ST_ACTIVE;
                        rem_d   = len_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (hits_q != '1) begin
                        hits_d = hits_q + 1'b1;
                    end
                    // len = 0 keeps the fault on until re-armed or reset.
                    if (len_q != '0) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign active_o = (state_q == ST_ACTIVE);
    assign target_o = tgt_q;
    assign mode_o   = mode_q;
    assign mask_o   = mask_q;
    assign hits_o   = hits_q;

endmodule

// File: rtl/pe_datapath_os_fi.sv
// pe_datapath_os_fi
// Output-stationary PE: unsigned MAC of in_a x in_b into a local accumulator,
// systolic forwarding of both operands, and a psum drain chain down the
// column. A run-time programmable fault (target, model, mask, timed window)
// can corrupt the north operand, the west operand or the stored psum.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_a, in_b            west / north operands
//   in_data               psum from the upstream PE of the drain chain
//   init_r                accumulator restart and drain strobe
//   in_valid_r            upstream drain data valid
//   data_rsrv             stage reserve
//   cfg_*                 fault configuration, loaded and armed by cfg_we
//   out_a, out_b          registered effective operands to the neighbours
//   out_data              drained psum
//   out_stagevalid_out    drain stage valid
//   fault_active          fault window currently open
//   fault_hits            number of faulted cycles since arm, saturating
//   sat_flag              sticky accumulator saturation flag
// ACC_W must be at least 2*D_W so the product fits the accumulator.
module pe_datapath_os_fi
    import pe_fi_pkg::*;
#(
    parameter int D_W    = 8,
    parameter int ACC_W  = 16,
    parameter int SAT_EN = 0,
    parameter int CNT_W  = 16,
    parameter int ROW    = 0,
    parameter int COL    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [D_W-1:0]   in_a,
    input  logic [D_W-1:0]   in_b,
    input  logic [ACC_W-1:0] in_data,
    input  logic             init_r,
    input  logic             in_valid_r,
    input  logic             data_rsrv,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_target,
    input  logic [1:0]       cfg_mode,
    input  logic [ACC_W-1:0] cfg_mask,
    input  logic [CNT_W-1:0] cfg_start,
    input  logic [CNT_W-1:0] cfg_len,
    output logic [D_W-1:0]   out_a,
    output logic [D_W-1:0]   out_b,
    output logic [ACC_W-1:0] out_data,
    output logic             out_stagevalid_out,
    output logic             fault_active,
    output logic [CNT_W-1:0] fault_hits,
    output logic             sat_flag
);

    // Array position is kept for trace/profiling tools only.
    logic [31:0] unused_pe_pos;
    assign unused_pe_pos = ROW ^ COL;

    logic             fi_active;
    fi_target_e       fi_target;
    fi_mode_e         fi_mode;
    logic [ACC_W-1:0] fi_mask;

    pe_fault_ctrl #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_fault_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we_i     (cfg_we),
        .cfg_target_i (cfg_target),
        .cfg_mode_i   (cfg_mode),
        .cfg_mask_i   (cfg_mask),
        .cfg_start_i  (cfg_start),
        .cfg_len_i    (cfg_len),
        .active_o     (fi_active),
        .target_o     (fi_target),
        .mode_o       (fi_mode),
        .mask_o       (fi_mask),
        .hits_o       (fault_hits)
    );

    // Registers
    logic [D_W-1:0]   a_tmp_q, b_tmp_q;
    logic [ACC_W-1:0] prod_q, prod_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] in_data_r_q;
    logic [ACC_W-1:0] out_stage_q, out_stage_d;
    logic             out_stagevalid_q, out_stagevalid_d;
    logic             out_data_valid_unused;
    logic [ACC_W-1:0] out_data_q, out_data_d;

    // Fault-corrupted candidates, built bit by bit
    logic [D_W-1:0]   a_flt, b_flt;
    logic [ACC_W-1:0] acc_sat, acc_flt;

    genvar gi;
    generate
        for (gi = 0; gi < D_W; gi++) begin : g_op_fault
            assign a_flt[gi] = fault_bit(in_a[gi], fi_mask[gi], fi_mode);
            assign b_flt[gi] = fault_bit(in_b[gi], fi_mask[gi], fi_mode);
        end
        for (gi = 0; gi < ACC_W; gi++) begin : g_psum_fault
            assign acc_flt[gi] = fault_bit(acc_sat[gi], fi_mask[gi], fi_mode);
        end
    endgenerate

    logic [D_W-1:0]   eff_a, eff_b;
    logic [2*D_W-1:0] mul;
    logic [ACC_W:0]   sum;
    logic             ovf;

    assign eff_a = (fi_active && fi_target == TGT_A) ? a_flt : in_a;
    assign eff_b = (fi_active && fi_target == TGT_W) ? b_flt : in_b;

    assign mul    = {{D_W{1'b0}}, eff_a} * {{D_W{1'b0}}, eff_b};
    assign prod_d = ACC_W'(mul);
    assign sum    = {1'b0, acc_q} + {1'b0, prod_q};

    // Accumulate (or restart), saturate if enabled, then corrupt the psum
    // last so saturation never masks an injected fault.
    always_comb begin
        ovf     = 1'b0;
        acc_sat = sum[ACC_W-1:0];
        if (init_r) begin
            acc_sat = prod_q;
        end else if (SAT_EN != 0 && sum[ACC_W]) begin
            acc_sat = '1;
            ovf     = 1'b1;
        end
    end

    assign sat_d = sat_q | ovf;
    assign acc_d = (fi_active && fi_target == TGT_P) ? acc_flt : acc_sat;

    // Drain chain, keyed on {init_r, in_valid_r, data_rsrv}
    logic [2:0] drain_k;
    assign drain_k = {init_r, in_valid_r, data_rsrv};
    assign out_data_valid_unused = 1'b0;

    always_comb begin
        out_stage_d      = out_stage_q;
        out_stagevalid_d = out_stagevalid_q;
        out_data_d       = in_data_r_q;
        case (drain_k)
            3'b110, 3'b111: begin
                out_stage_d      = in_data_r_q;
                out_stagevalid_d = 1'b1;
            end
            3'b011: begin
                out_stage_d      = in_data_r_q;
                out_stagevalid_d = in_valid_r;
            end
            3'b100, 3'b101: out_stagevalid_d = 1'b1;
            default: ;
        endcase
        if (init_r) begin
            out_data_d = acc_q;
        end else if (data_rsrv) begin
            out_data_d = out_stage_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_tmp_q          <= '0;
            b_tmp_q          <= '0;
            prod_q           <= '0;
            acc_q            <= '0;
            sat_q            <= 1'b0;
            in_data_r_q      <= '0;
            out_stage_q      <= '0;
            out_stagevalid_q <= 1'b0;
            out_data_q       <= '0;
        end else begin
            a_tmp_q          <= eff_a;
            b_tmp_q          <= eff_b;
            prod_q           <= prod_d;
            acc_q            <= acc_d;
            sat_q            <= sat_d;
            in_data_r_q      <= in_data;
            out_stage_q      <= out_stage_d;
            out_stagevalid_q <= out_stagevalid_d;
            out_data_q       <= out_data_d;
        end
    end

    assign out_a              = a_tmp_q;
    assign out_b              = b_tmp_q;
    assign out_data           = out_data_q;
    assign out_stagevalid_out = out_stagevalid_q;
    assign fault_active       = fi_active;
    assign sat_flag           = sat_q;

endmodule

// File: tb/tb_pe_datapath_os_fi.sv
// Self-checking bench: two PEs (wrapping and saturating) share all inputs.
// The driver computes each cycle's expected outputs from a behavioural model
// (fault window expressed as an absolute cycle interval) and queues them; a
// monitor pops one entry after every clock edge and compares.
module tb_pe_datapath_os_fi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_a = '0, in_b = '0;
    logic [15:0] in_data = '0;
    logic        init_r = 1'b0, in_valid_r = 1'b0, data_rsrv = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_target = '0, cfg_mode = '0;
    logic [15:0] cfg_mask = '0, cfg_start = '0, cfg_len = '0;

    logic [7:0]  oa[2], ob[2];
    logic [15:0] od[2], oh[2];
    logic        osv[2], ofa[2], osat[2];

    always #5 clk = ~clk;

    pe_datapath_os_fi #(.D_W(8), .ACC_W(16), .SAT_EN(0), .CNT_W(16), .ROW(0), .COL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_data(in_data),
        .init_r(init_r), .in_valid_r(in_valid_r), .data_rsrv(data_rsrv),
        .cfg_we(cfg_we), .cfg_target(cfg_target), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask),
        .cfg_start(cfg_start), .cfg_len(cfg_len),
        .out_a(oa[0]), .out_b(ob[0]), .out_data(od[0]), .out_stagevalid_out(osv[0]),
        .fault_active(ofa[0]), .fault_hits(oh[0]), .sat_flag(osat[0]));

    pe_datapath_os_fi #(.D_W(8), .ACC_W(16), .SAT_EN(1), .CNT_W(16), .ROW(0), .COL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_data(in_data),
        .init_r(init_r), .in_valid_r(in_valid_r), .data_rsrv(data_rsrv),
        .cfg_we(cfg_we), .cfg_target(cfg_target), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask),
        .cfg_start(cfg_start), .cfg_len(cfg_len),
        .out_a(oa[1]), .out_b(ob[1]), .out_data(od[1]), .out_stagevalid_out(osv[1]),
        .fault_active(ofa[1]), .fault_hits(oh[1]), .sat_flag(osat[1]));

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- expected-output scoreboard ----------------
    typedef struct {
        logic [7:0]  a, b;
        logic [15:0] d[2];
        logic        osv, fa;
        logic [15:0] hits;
        logic        sat[2];
    } exp_t;
    exp_t sb[$];

    // ---------------- reference model ----------------
    int          kc;                 // cycle index; cycle k ends at edge E_k
    bit          w_valid;            // a fault window is programmed
    int          ws;                 // first faulted cycle
    int          wlen;               // 0 = permanent
    logic [1:0]  wt, wm;
    logic [15:0] wmask;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_prod, m_indr, m_stage;
    logic [15:0] m_acc[2], m_od[2];
    logic        m_osv, m_sat[2];

    function automatic logic [15:0] fm(input logic [15:0] x, input logic [15:0] m, input logic [1:0] mode);
        if (mode == 2'd1) return x & ~m;
        if (mode == 2'd2) return x | m;
        return x ^ m;
    endfunction

    function automatic bit win_active(input int k);
        return w_valid && k >= ws && (wlen == 0 || k < ws + wlen);
    endfunction

    function automatic int hits_at(input int k);
        int last;
        if (!w_valid || k < ws) return 0;
        last = (wlen == 0 || k < ws + wlen - 1) ? k : ws + wlen - 1;
        return (last - ws + 1 > 65535) ? 65535 : last - ws + 1;
    endfunction

    task automatic model_reset();
        w_valid = 0; ws = 0; wlen = 0; wt = '0; wm = '0; wmask = '0;
        m_a = '0; m_b = '0; m_prod = '0; m_indr = '0; m_stage = '0; m_osv = 1'b0;
        for (int s = 0; s < 2; s++) begin
            m_acc[s] = '0; m_od[s] = '0; m_sat[s] = 1'b0;
        end
    endtask

    function automatic exp_t snap(input int k);
        exp_t e;
        e.a = m_a; e.b = m_b; e.osv = m_osv;
        e.fa = win_active(k + 1);
        e.hits = 16'(hits_at(k));
        for (int s = 0; s < 2; s++) begin
            e.d[s] = m_od[s]; e.sat[s] = m_sat[s];
        end
        return e;
    endfunction

    // One clock cycle of stimulus plus the model's prediction for its edge.
    task automatic cyc(input logic [7:0] a, input logic [7:0] b, input logic [15:0] ind,
                       input logic ini, input logic inv, input logic rsv,
                       input logic we = 1'b0, input logic [1:0] tgt = 2'd3, input logic [1:0] mode = 2'd0,
                       input logic [15:0] mask = 16'd0, input logic [15:0] start = 16'd0,
                       input logic [15:0] len = 16'd0);
        bit          act;
        logic [7:0]  ea, eb;
        logic [15:0] tmp, prod_n, na;
        logic [16:0] sum;
        logic [2:0]  kk;
        @(negedge clk);
        rst_n = 1'b1;
        in_a = a; in_b = b; in_data = ind; init_r = ini; in_valid_r = inv; data_rsrv = rsv;
        cfg_we = we; cfg_target = tgt; cfg_mode = mode; cfg_mask = mask;
        cfg_start = start; cfg_len = len;

        act = win_active(kc);
        ea = a; eb = b;
        if (act && wt == 2'd0) begin tmp = fm({8'd0, b}, wmask, wm); eb = tmp[7:0]; end
        if (act && wt == 2'd1) begin tmp = fm({8'd0, a}, wmask, wm); ea = tmp[7:0]; end
        prod_n = {8'd0, ea} * {8'd0, eb};
        for (int s = 0; s < 2; s++) begin
            sum = {1'b0, m_acc[s]} + {1'b0, m_prod};
            if (ini) na = m_prod;
            else if (sum > 17'h0FFFF && s == 1) begin na = 16'hFFFF; m_sat[1] = 1'b1; end
            else na = sum[15:0];
            if (act && wt == 2'd2) na = fm(na, wmask, wm);
            m_od[s] = ini ? m_acc[s] : (rsv ? m_stage : m_indr);
            m_acc[s] = na;
        end
        kk = {ini, inv, rsv};
        if (kk == 3'b110 || kk == 3'b111 || kk == 3'b011) m_stage = m_indr;
        if (ini) m_osv = 1'b1;
        else if (kk == 3'b011) m_osv = inv;
        m_a = ea; m_b = eb; m_prod = prod_n; m_indr = ind;
        if (we) begin
            w_valid = (tgt != 2'd3);
            ws = kc + 2 + int'(start);
            wlen = int'(len); wt = tgt; wm = mode; wmask = mask;
        end
        sb.push_back(snap(kc));
        kc++;
    endtask

    // Reset cycle; optionally verify that every output drops before any edge.
    task automatic do_reset(input bit check);
        @(negedge clk);
        rst_n = 1'b0;
        cfg_we = 1'b0; init_r = 1'b0; in_valid_r = 1'b0; data_rsrv = 1'b0;
        #1;
        if (check) begin
            for (int s = 0; s < 2; s++) begin
                chk("async_rst_out_a", oa[s], 0);
                chk("async_rst_out_b", ob[s], 0);
                chk("async_rst_out_data", od[s], 0);
                chk("async_rst_stagevalid", osv[s], 0);
                chk("async_rst_fault_active", ofa[s], 0);
                chk("async_rst_fault_hits", oh[s], 0);
                chk("async_rst_sat_flag", osat[s], 0);
            end
        end
        model_reset();
        sb.push_back(snap(kc));
        kc++;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        int   n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int s = 0; s < 2; s++) begin
                    chk(s == 0 ? "out_a[wrap]" : "out_a[sat]", oa[s], e.a);
                    chk(s == 0 ? "out_b[wrap]" : "out_b[sat]", ob[s], e.b);
                    chk(s == 0 ? "out_data[wrap]" : "out_data[sat]", od[s], e.d[s]);
                    chk(s == 0 ? "stagevalid[wrap]" : "stagevalid[sat]", osv[s], e.osv);
                    chk(s == 0 ? "fault_active[wrap]" : "fault_active[sat]", ofa[s], e.fa);
                    chk(s == 0 ? "fault_hits[wrap]" : "fault_hits[sat]", oh[s], e.hits);
                    chk(s == 0 ? "sat_flag[wrap]" : "sat_flag[sat]", osat[s], e.sat[s]);
                end
                $display("txn %0d: a=%0d b=%0d data=%0h/%0h sv=%0b fa=%0b hits=%0d",
                         n, oa[0], ob[0], od[0], od[1], osv[0], ofa[0], oh[0]);
                n++;
            end
        end
    end

    // Watchdog: the bench must always end on its own.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        kc = 0;
        model_reset();
        do_reset(1'b0);
        do_reset(1'b1);

        // No fault: 3*5 four times -> 60, drained on the next init_r.
        cyc(8'd3, 8'd5, 16'd0, 1'b0, 1'b0, 1'b0);
        cyc(8'd3, 8'd5, 16'd0, 1'b1, 1'b0, 1'b0);
        cyc(8'd3, 8'd5, 16'd0, 1'b0, 1'b0, 1'b0);
        cyc(8'd3, 8'd5, 16'd0, 1'b0, 1'b0, 1'b0);
        cyc(8'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        cyc(8'd0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("nofault_drain_60", od[0], 60);
        chk("nofault_hits_0", oh[0], 0);

        // Saturation: 255*255 accumulated twice.
        cyc(8'd255, 8'd255, 16'd0, 1'b0, 1'b0, 1'b0);
        cyc(8'd255, 8'd255, 16'd0, 1'b1, 1'b0, 1'b0);
        cyc(8'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        cyc(8'd0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("wrap_acc_FC02", od[0], 16'hFC02);
        chk("sat_acc_FFFF", od[1], 16'hFFFF);
        chk("sat_flag_set", osat[1], 1);
        chk("wrap_sat_flag_clear", osat[0], 0);

        // Weight flip, mask 0x01, start 2, len 1: one product 2*5 = 10.
        cyc(8'd2, 8'd4, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 16'h0001, 16'd2, 16'd1);
        for (int i = 0; i < 8; i++) cyc(8'd2, 8'd4, 16'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("tgtw_hits_1", oh[0], 1);
        chk("tgtw_done_inactive", ofa[0], 0);

        // Input stuck-at-1 on bit 7, permanent: 100 active cycles.
        cyc(8'($urandom), 8'($urandom), 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2, 16'h0080, 16'd0, 16'd0);
        for (int i = 0; i < 101; i++) cyc(8'($urandom), 8'($urandom), 16'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("tgta_perm_active", ofa[0], 1);
        chk("tgta_hits_100", oh[0], 100);
        chk("tgta_bit7_set", 32'(oa[0][7]), 1);

        // Psum stuck-at-0 on the LSB over an odd running sum.
        cyc(8'd1, 8'd1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 16'h0001, 16'd1, 16'd4);
        for (int i = 0; i < 10; i++) cyc(8'd1, 8'd1, 16'd0, 1'b0, 1'b0, 1'b0);
        cyc(8'd0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a permanent psum flip window.
        cyc(8'd7, 8'd9, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 16'hFFFF, 16'd0, 16'd0);
        for (int i = 0; i < 5; i++) cyc(8'd7, 8'd9, 16'h1234, 1'b0, 1'b1, 1'b1);
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) cyc(8'd7, 8'd9, 16'h00AA, 1'b0, 1'b1, 1'b0);

        // Randomised traffic with occasional re-configuration.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0)
                cyc(8'($urandom), 8'($urandom), 16'($urandom), 1'($urandom_range(0, 5) == 0),
                    1'($urandom), 1'($urandom), 1'b1, 2'($urandom), 2'($urandom), 16'($urandom),
                    16'($urandom_range(0, 5)), 16'($urandom_range(0, 6)));
            else
                cyc(8'($urandom), 8'($urandom), 16'($urandom), 1'($urandom_range(0, 5) == 0),
                    1'($urandom), 1'($urandom));
        end

        @(posedge clk); #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
